// File: rtl/proc_param.sv
// Multi-cycle processor: eight registers, shared bus, A/G around an ALU.
// One instruction at a time, two or four steps, controlled by a 2-bit step counter.
module proc_param #(
  parameter int N = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [N-1:0] DIN,
  input  logic         Run,
  output logic         Done,
  output logic [N-1:0] BusOutput
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  logic [N-1:0] r [8];
  logic [N-1:0] a;
  logic [N-1:0] g;
  logic [8:0]   ir;
  logic         z;
  logic [1:0]   step;

  logic [2:0]   op;
  logic [2:0]   rx;
  logic [2:0]   ry;
  logic         is_alu;
  logic         rx_we;
  logic [N-1:0] bus;
  logic [N-1:0] alu;

  assign op = ir[8:6];
  assign rx = ir[5:3];
  assign ry = ir[2:0];

  assign is_alu = (op == OP_ADD) || (op == OP_SUB)
               || (op == OP_AND) || (op == OP_SLT);

  always_comb begin
    bus = DIN;
    case (step)
      T1: begin
        if (is_alu)
          bus = r[rx];
        else if ((op == OP_MV) || (op == OP_MVNZ))
          bus = r[ry];
        else
          bus = DIN;
      end
      T2:      bus = r[ry];
      T3:      bus = g;
      default: bus = DIN;
    endcase
  end

  always_comb begin
    alu = a + bus;
    case (op)
      OP_ADD:  alu = a + bus;
      OP_SUB:  alu = a - bus;
      OP_AND:  alu = a & bus;
      OP_SLT:  alu = {{(N-1){1'b0}}, ($signed(a) < $signed(bus))};
      default: alu = a + bus;
    endcase
  end

  // MVNZ is the only conditional write; it reads the Z left by the last ALU op
  assign rx_we = ((step == T1) && ((op == OP_MV) || (op == OP_MVI)
                || ((op == OP_MVNZ) && !z)))
              || (step == T3);

  assign Done      = ((step == T1) && !is_alu) || (step == T3);
  assign BusOutput = bus;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) r[i] <= '0;
      a    <= '0;
      g    <= '0;
      ir   <= '0;
      z    <= 1'b1;
      step <= T0;
    end else begin
      if (rx_we) r[rx] <= bus;
      case (step)
        T0: begin
          if (Run) begin
            ir   <= DIN[8:0];
            step <= T1;
          end
        end
        T1: begin
          if (is_alu) begin
            a    <= bus;
            step <= T2;
          end else begin
            step <= T0;
          end
        end
        T2: begin
          g    <= alu;
          z    <= (alu == '0);
          step <= T3;
        end
        default: step <= T0;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_param.sv
// Directed bench for proc_param: instruction vector table plus
// reset and mid-instruction abort sequences.
module tb_proc_param;

  logic        Clock;
  logic        Reset;
  logic [15:0] DIN;
  logic        Run;
  logic        Done;
  logic [15:0] BusOutput;

  int checks = 0;
  int errors = 0;

  proc_param #(.N(16)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .DIN      (DIN),
    .Run      (Run),
    .Done     (Done),
    .BusOutput(BusOutput)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [8:0]  ins;
    logic [15:0] imm;
    logic        hold;
    int          cyc;
    logic        chk_bus;
    logic [15:0] res;
    logic [2:0]  rg;
    logic [15:0] rv;
    logic        chk_z;
    logic        z;
  } vec_t;

  vec_t v [17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_instr(input logic [8:0] ins, input logic [15:0] imm,
                           input logic hold, output logic [15:0] res,
                           output int cyc);
    @(negedge Clock);
    Run = 1'b1;
    DIN = {7'b0, ins};
    @(posedge Clock);
    @(negedge Clock);
    Run = hold;
    DIN = imm;
    cyc = 0;
    res = 'x;
    for (int k = 1; k <= 5; k++) begin
      #1;
      if (Done) begin
        res = BusOutput;
        cyc = k + 1;
        break;
      end
      @(posedge Clock);
      @(negedge Clock);
    end
    if (cyc == 0) chk("done_timeout", 32'd0, 32'd1);
    @(posedge Clock);
    #1 Run = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
    int c;
    run_instr({3'b000, idx, idx}, 16'h0, 1'b0, val, c);
  endtask

  initial begin
    logic [15:0] res;
    logic [15:0] rv;
    int          cyc;

    v[0]  = '{9'h040, 16'h1234, 1'b0, 2, 1'b1, 16'h1234, 3'd0, 16'h1234, 1'b1, 1'b1};
    v[1]  = '{9'h008, 16'hBEEF, 1'b0, 2, 1'b1, 16'h1234, 3'd1, 16'h1234, 1'b1, 1'b1};
    v[2]  = '{9'h081, 16'h0000, 1'b1, 4, 1'b1, 16'h2468, 3'd0, 16'h2468, 1'b1, 1'b0};
    v[3]  = '{9'h050, 16'h0000, 1'b0, 2, 1'b1, 16'h0000, 3'd2, 16'h0000, 1'b1, 1'b0};
    v[4]  = '{9'h058, 16'h0001, 1'b0, 2, 1'b1, 16'h0001, 3'd3, 16'h0001, 1'b0, 1'b0};
    v[5]  = '{9'h0D3, 16'h0000, 1'b0, 4, 1'b1, 16'hFFFF, 3'd2, 16'hFFFF, 1'b1, 1'b0};
    v[6]  = '{9'h060, 16'hFFFF, 1'b0, 2, 1'b1, 16'hFFFF, 3'd4, 16'hFFFF, 1'b0, 1'b0};
    v[7]  = '{9'h068, 16'h0001, 1'b0, 2, 1'b1, 16'h0001, 3'd5, 16'h0001, 1'b0, 1'b0};
    v[8]  = '{9'h165, 16'h0000, 1'b0, 4, 1'b1, 16'h0001, 3'd4, 16'h0001, 1'b1, 1'b0};
    v[9]  = '{9'h068, 16'hFFFF, 1'b0, 2, 1'b1, 16'hFFFF, 3'd5, 16'hFFFF, 1'b0, 1'b0};
    v[10] = '{9'h165, 16'h0000, 1'b0, 4, 1'b1, 16'h0000, 3'd4, 16'h0000, 1'b1, 1'b1};
    v[11] = '{9'h1B0, 16'h0000, 1'b0, 2, 1'b1, 16'h2468, 3'd6, 16'h0000, 1'b1, 1'b1};
    v[12] = '{9'h101, 16'h0000, 1'b0, 4, 1'b1, 16'h0020, 3'd0, 16'h0020, 1'b1, 1'b0};
    v[13] = '{9'h1B0, 16'h0000, 1'b0, 2, 1'b1, 16'h0020, 3'd6, 16'h0020, 1'b1, 1'b0};
    v[14] = '{9'h0C9, 16'h0000, 1'b0, 4, 1'b1, 16'h0000, 3'd1, 16'h0000, 1'b1, 1'b1};
    v[15] = '{9'h09B, 16'h0000, 1'b0, 4, 1'b1, 16'h0002, 3'd3, 16'h0002, 1'b1, 1'b0};
    v[16] = '{9'h1C0, 16'hABCD, 1'b0, 2, 1'b0, 16'h0000, 3'd3, 16'h0002, 1'b1, 1'b0};

    Reset = 1'b1;
    Run   = 1'b1;
    DIN   = 16'h5A5A;
    repeat (2) @(negedge Clock);
    #1;
    chk("reset_done", Done, 1'b0);
    chk("reset_bus", BusOutput, 16'h5A5A);
    chk("reset_z", dut.z, 1'b1);
    @(negedge Clock);
    Reset = 1'b0;
    Run   = 1'b0;
    read_reg(3'd5, rv);
    chk("reset_r5", rv, 16'h0000);

    for (int i = 0; i < 17; i++) begin
      run_instr(v[i].ins, v[i].imm, v[i].hold, res, cyc);
      chk($sformatf("v%0d_cycles", i), cyc, v[i].cyc);
      if (v[i].chk_bus)
        chk($sformatf("v%0d_result", i), res, v[i].res);
      read_reg(v[i].rg, rv);
      chk($sformatf("v%0d_reg", i), rv, v[i].rv);
      if (v[i].chk_z)
        chk($sformatf("v%0d_z", i), dut.z, v[i].z);
    end

    // Abort ADD R0,R1 in T2; R0 currently 0x0020
    @(negedge Clock);
    Run = 1'b1;
    DIN = 16'h0081;
    @(posedge Clock);
    @(negedge Clock);
    Run = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    Run   = 1'b1;
    DIN   = 16'h1111;
    #1;
    chk("abort_done", Done, 1'b0);
    chk("abort_bus", BusOutput, 16'h1111);
    chk("abort_step", dut.step, 2'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    #1;
    chk("abort_hold_bus", BusOutput, 16'h1111);
    Reset = 1'b0;
    Run   = 1'b0;
    read_reg(3'd0, rv);
    chk("abort_r0", rv, 16'h0000);
    read_reg(3'd3, rv);
    chk("abort_r3", rv, 16'h0000);
    run_instr(9'h040, 16'h0BEE, 1'b0, res, cyc);
    chk("post_mvi_cycles", cyc, 2);
    read_reg(3'd0, rv);
    chk("post_mvi_r0", rv, 16'h0BEE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_param.md
PROC_PARAM -- requirements
Module: proc_param

Interface
REQ-001 The parameter list SHALL be: N, 16, data/register/bus width in bits, legal range 9..32.
REQ-002 The ports SHALL be: Clock  input  1  single system clock, rising-edge active.
REQ-003 The ports SHALL include: Reset  input  1  asynchronous, active-high reset.
REQ-004 The ports SHALL include: DIN  input  N  instruction word (bits [8:0]) or MVI immediate.
REQ-005 The ports SHALL include: Run  input  1  start request, sampled only in step T0.
REQ-006 The ports SHALL include: Done  output  1  high during the final step of each instruction.
REQ-007 The ports SHALL include: BusOutput  output  N  current value of the internal bus.

Function
REQ-008 The block SHALL hold the following state:
  - eight N-bit registers R0..R7;
  - an N-bit A register and an N-bit G register;
  - a 9-bit IR;
  - a Z flag;
  - a 2-bit step counter (T0..T3).
REQ-009 IR decoding SHALL be: opcode IR[8:6], Rx IR[5:3], Ry IR[2:0].
REQ-010 Opcodes SHALL be:
  - 000 MV, 001 MVI, 010 ADD, 011 SUB;
  - 100 AND, 101 SLT, 110 MVNZ, 111 NOP.
REQ-011 In T0 with Run=0: no state SHALL change, step SHALL stay T0, bus=DIN.
REQ-012 In T0 with Run=1: IR SHALL load DIN[8:0] at the clock edge and step SHALL advance to T1.
REQ-013 In T1 the single-step opcodes SHALL complete with Done=1, then step SHALL return to T0:
  - MV: bus=Ry, Rx loads bus.
  - MVI: bus=DIN, Rx loads bus.
  - MVNZ: bus=Ry, Rx loads bus only if Z=0.
  - NOP: no register write.
REQ-014 In T1, for ADD/SUB/AND/SLT: bus=Rx, A loads bus, step SHALL advance to T2, Done=0.
REQ-015 In T2: bus=Ry, G SHALL load ALU(A, bus), Z SHALL load (ALU result == 0), step SHALL advance to T3, Done=0.
REQ-016 In T3: bus=G, Rx SHALL load bus, Done=1, step SHALL return to T0.
REQ-017 ALU operations SHALL be:
  - ADD: A+B mod 2^N.
  - SUB: A-B mod 2^N.
  - AND: bitwise AND.
  - SLT: 1 (zero-extended to N) if A<B as signed two's complement, else 0.
REQ-018 Carry and overflow SHALL be discarded; no flag other than Z exists.
REQ-019 Z SHALL change only in T2 of ALU instructions; MV, MVI, MVNZ and NOP SHALL leave Z and G unchanged.
REQ-020 Rx==Ry SHALL be legal and SHALL behave as specified (ADD R1,R1 doubles R1; SUB R1,R1 yields 0 and Z=1).
REQ-021 Run SHALL be ignored in T1..T3; a new instruction SHALL start no earlier than the T0 following Done.
REQ-022 Done SHALL be a combinational decode of step and opcode only, and SHALL be high for exactly one cycle per instruction.
REQ-023 Latency SHALL be 2 cycles (T0+T1) for MV/MVI/MVNZ/NOP and 4 cycles (T0..T3) for ADD/SUB/AND/SLT.
REQ-024 At most one register SHALL be written per clock edge.
REQ-025 BusOutput SHALL always equal the bus value selected for the current step.

Reset
REQ-026 Reset=1 SHALL asynchronously clear R0..R7, A, G, IR and step to 0, and set Z=1.
REQ-027 While Reset=1, Done SHALL be 0 and BusOutput SHALL equal DIN (step T0).
REQ-028 Reset asserted mid-instruction SHALL abort it, with no register write on any edge during reset.
REQ-029 After Reset deasserts, the first rising edge with Run=1 SHALL perform a normal fetch.

Verification
REQ-030 MVI (N=16): Reset; Run=1 with DIN=0x040 (MVI R0); next cycle DIN=0x1234 -> R0=0x1234, Done=1 in T1 only, total 2 cycles.
REQ-031 MV: DIN=0x008 (MV R1,R0) after REQ-030 -> R1=0x1234, Done pulses once, A/G/Z unchanged.
REQ-032 ADD, then SUB wrap:
  - ADD R0,R1 (0x081) -> R0=0x2468 at end of T3, Done only in T3, Z=0.
  - With R2=0x0000 and R3=0x0001, SUB R2,R3 -> R2=0xFFFF.
REQ-033 SLT: R4=0xFFFF, R5=0x0001; SLT R4,R5 -> R4=0x0001. Then R4=0x0001, R5=0xFFFF; SLT R4,R5 -> R4=0x0000, Z=1.
REQ-034 MVNZ:
  - After SUB leaving G=0: MVNZ R6,R0 -> R6 unchanged, Done=1.
  - After ADD leaving G≠0: MVNZ R6,R0 -> R6=R0.
REQ-035 Reset in T2 of ADD R0,R1 -> R0 stays 0 (cleared), step=T0, Done=0; a following MVI executes normally.
